axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

- Synthesizable AXI4-Lite master that executes single read/write commands from a valid/ready command port.
- Drives them onto an AXI4-Lite bus with independent AW/W channel handling.
- Returns response data and status on a valid/ready response port.
- Sits in front of AXI-Lite register slaves such as the FIR core. Used for on-chip coefficient/configuration loading and for self-checking hardware benches.
- Keeps a saturating error counter.

## Interface
Parameters:
- C_M00_AXI_ADDR_WIDTH, 32, address width.
- C_M00_AXI_DATA_WIDTH, 32, data width (32 or 64).
- C_TIMEOUT_CYCLES, 256, handshake timeout limit; used only with AXIL_TIMEOUT_EN.

Ports:
- s00_axi_aclk  in  1  single clock; all logic on rising edge.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction timed out.
- err_count  out  16  saturating count of non-OKAY or timed-out responses.
- busy  out  1  high in any state other than IDLE.
- m00_axi_*: full AXI4-Lite master set:
  - awaddr, awprot, awvalid/awready
  - wdata, wstrb, wvalid/wready
  - bresp, bvalid/bready
  - araddr, arprot, arvalid/arready
  - rdata, rresp, rvalid/rready
  - awprot and arprot are tied to 3'b000.

## Operation
States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.

- **IDLE**
  - cmd_ready = 1.
  - On accept, register addr, data, strobe and direction.
  - Go to WR_AW_W if cmd_write = 1, else RD_AR.
- **WR_AW_W**
  - awvalid and wvalid are both asserted on entry.
  - Each valid drops independently on the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_B once both handshakes are done.
- **WR_B**
  - bready = 1.
  - On bvalid, capture bresp and go to RSP.
- **RD_AR**
  - arvalid = 1 until arready, then go to RD_R.
- **RD_R**
  - rready = 1.
  - On rvalid, capture rdata and rresp, then go to RSP.
- **RSP**
  - rsp_valid = 1, with rsp_* fields held stable.
  - On rsp_ready, return to IDLE.
  - err_count increments on the rsp_valid && rsp_ready cycle if rsp_resp != 2'b00 or rsp_timeout = 1. It saturates at 16'hFFFF.

Rules:
- No valid signal ever depends on its ready.
- Once asserted, a valid holds until its handshake completes (or until a timeout).
- Only one transaction is outstanding at a time.
- cmd_* inputs are ignored outside IDLE.

## Timing
Reset:
- While s00_axi_aresetn = 0 at a clock edge, every output is 0: cmd_ready, all valid/ready outputs, rsp_*, err_count and busy.
- Reset asserted mid-transaction abandons it immediately. The state returns to IDLE and err_count clears.
- cmd_ready rises on the first edge after reset is released.

Latency (command accepted at edge N):
- awvalid/wvalid or arvalid are high from N+1.
- With a zero-wait slave, the AW/W (or AR) handshake occurs at N+1 and bready/rready is high at N+2.
- rsp_valid rises on the edge after the B or R handshake.
- Zero-wait write: command at N, rsp_valid at N+3. Same for reads.

Back-to-back:
- Minimum of 1 IDLE cycle between rsp_ready and the next command acceptance.

## Configuration
- **AXIL_TIMEOUT_EN defined**
  - A counter clears on every state entry and counts each cycle spent in WR_AW_W, WR_B, RD_AR or RD_R.
  - When it reaches C_TIMEOUT_CYCLES, all master valid/ready outputs drop on the next edge and the block goes to RSP with rsp_timeout = 1, rsp_resp = 2'b10 and rsp_rdata = 0.
  - After a timeout, slave state is undefined; software must reset the system.
- **AXIL_TIMEOUT_EN undefined**
  - No counter is built.
  - The block waits indefinitely in each state.
  - rsp_timeout is tied to 0.

## Test plan
- **Zero-wait write:** write addr 0x4, data 85 (0x55), wstrb 4'hF; slave always ready, bresp 00.
  - Expect awaddr = 0x4 and wdata = 0x55 at N+1.
  - Expect rsp_valid at N+3 with rsp_resp = 00, rsp_write = 1 and err_count = 0.
- **Skewed AW/W:** write addr 0x0, data 0xABCD1234; slave gives awready at N+1 but wready at N+4.
  - Expect awvalid low from N+2 while wvalid stays high through N+4.
  - Expect exactly one B handshake, then rsp_resp = 00.
- **Read:** read addr 0x0; slave gives arready after 2 cycles and rvalid with rdata 0xABCD1234, rresp 00.
  - Expect rsp_rdata = 0xABCD1234 and rsp_write = 0.
- **Slave error:** write with bresp = 2'b10, then hold rsp_ready low for 5 cycles.
  - Expect rsp_valid and rsp_resp = 10 held stable for all 5 cycles.
  - Expect err_count = 1 after the handshake.
  - Five further error writes give err_count = 6.
- **Timeout** (AXIL_TIMEOUT_EN, C_TIMEOUT_CYCLES = 16): awready never asserted.
  - Expect awvalid to drop after 16 cycles.
  - Expect rsp_timeout = 1, rsp_resp = 10 and err_count incremented.
  - Without the macro, awvalid stays high for 100+ cycles.
- **Reset mid-write:** assert aresetn = 0 during WR_B.
  - Expect all outputs 0 at the next edge.
  - Expect cmd_ready = 1 on the first edge after release.
  - A fresh write then completes normally.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// The master modport drives address/data/valid and response-ready signals;
// the slave modport is the mirror image.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-command master.
// Accepts one read/write command at a time on a valid/ready port, runs it on
// the AXI4-Lite bus (AW and W handled independently), and returns the data and
// response on a valid/ready response port. Non-OKAY or timed-out responses are
// counted in a saturating 16-bit error counter.
// Optional feature macro: AXIL_TIMEOUT_EN -- when defined, a per-state cycle
// counter aborts a stalled handshake after C_TIMEOUT_CYCLES cycles and returns
// rsp_timeout = 1 with a SLVERR-coded response.
module axil_cmd_master #(
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES     = 256
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  // command port
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  // status
  output logic [15:0]                       err_count,
  output logic                              busy,
  // AXI4-Lite master bus
  axil_cmd_master_if.master                 m00_axi
);

  localparam int STRB_W = C_M00_AXI_DATA_WIDTH / 8;

  // Elaboration-time sanity checks on the configuration.
  if ((C_M00_AXI_DATA_WIDTH != 32) && (C_M00_AXI_DATA_WIDTH != 64)) begin : g_bad_width
    $error("axil_cmd_master: data width must be 32 or 64");
  end
  if (C_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axil_cmd_master: timeout limit must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                            state_reg, state_next;
  logic                              active_reg;   // low until the first edge after reset release
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   addr_reg;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_W-1:0]                 wstrb_reg;
  logic                              aw_done_reg;
  logic                              w_done_reg;
  logic                              rsp_write_reg;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [1:0]                        rsp_resp_reg;
  logic                              rsp_timeout_reg;
  logic [15:0]                       err_count_reg;

  logic cmd_accept;
  logic aw_pending, w_pending;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic rsp_hs;
  logic in_wait;
  logic timeout_hit;
  logic timeout_take;

  // Valids come purely from state and done flags, never from the matching ready.
  assign aw_pending = (state_reg == WR_AW_W) && !aw_done_reg;
  assign w_pending  = (state_reg == WR_AW_W) && !w_done_reg;

  assign aw_hs  = aw_pending && m00_axi.awready;
  assign w_hs   = w_pending && m00_axi.wready;
  assign b_hs   = (state_reg == WR_B) && m00_axi.bvalid;
  assign ar_hs  = (state_reg == RD_AR) && m00_axi.arready;
  assign r_hs   = (state_reg == RD_R) && m00_axi.rvalid;
  assign rsp_hs = (state_reg == RSP) && rsp_ready;

  assign cmd_ready  = active_reg && (state_reg == IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  assign in_wait = (state_reg == WR_AW_W) || (state_reg == WR_B) ||
                   (state_reg == RD_AR)   || (state_reg == RD_R);

`ifdef AXIL_TIMEOUT_EN
  localparam int TO_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;

  // The current cycle is the last one allowed in this wait state.
  assign timeout_hit = in_wait && (to_cnt_reg == TO_W'(C_TIMEOUT_CYCLES - 1));

  // Per-state cycle counter: restarts on every state change.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      to_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      to_cnt_reg <= '0;
    end else if (in_wait) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic; a timeout only wins when no handshake completes this cycle.
  always_comb begin
    state_next   = state_reg;
    timeout_take = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) state_next = cmd_write ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_B;
      end
      WR_B: begin
        if (b_hs) state_next = RSP;
      end
      RD_AR: begin
        if (ar_hs) state_next = RD_R;
      end
      RD_R: begin
        if (r_hs) state_next = RSP;
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit && (state_next == state_reg)) begin
      timeout_take = 1'b1;
      state_next   = RSP;
    end
  end

  // State register plus command capture, handshake tracking and response capture.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_reg       <= IDLE;
      active_reg      <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      rsp_write_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= 2'b00;
      rsp_timeout_reg <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (cmd_accept) begin
            addr_reg        <= cmd_addr;
            wdata_reg       <= cmd_wdata;
            wstrb_reg       <= cmd_wstrb;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            rsp_write_reg   <= cmd_write;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b00;
            rsp_timeout_reg <= 1'b0;
          end
        end
        WR_AW_W: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
        end
        WR_B: begin
          if (b_hs) rsp_resp_reg <= m00_axi.bresp;
        end
        RD_R: begin
          if (r_hs) begin
            rsp_rdata_reg <= m00_axi.rdata;
            rsp_resp_reg  <= m00_axi.rresp;
          end
        end
        RSP: begin
          if (rsp_hs && ((rsp_resp_reg != 2'b00) || rsp_timeout_reg) &&
              (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
          end
        end
        default: ;
      endcase
      if (timeout_take) begin
        rsp_rdata_reg   <= '0;
        rsp_resp_reg    <= 2'b10;
        rsp_timeout_reg <= 1'b1;
      end
    end
  end

  // Bus outputs: addresses/data come from the captured command, protection fixed.
  assign m00_axi.awaddr  = addr_reg;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awvalid = aw_pending;
  assign m00_axi.wdata   = wdata_reg;
  assign m00_axi.wstrb   = wstrb_reg;
  assign m00_axi.wvalid  = w_pending;
  assign m00_axi.bready  = (state_reg == WR_B);
  assign m00_axi.araddr  = addr_reg;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = (state_reg == RD_AR);
  assign m00_axi.rready  = (state_reg == RD_R);

  assign rsp_valid   = (state_reg == RSP);
  assign rsp_write   = rsp_write_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign err_count   = err_count_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable AXI4-Lite slave.
// Timing language: the value "at edge N+k" is what is visible just after edge
// N+k-1, so samples are taken 1 time unit after each rising edge.
module tb_axil_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          s00_axi_aclk = 1'b0;
  logic          s00_axi_aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [15:0]   err_count;
  logic          busy;

  axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m00_axi ();

  axil_cmd_master #(
    .C_M00_AXI_ADDR_WIDTH(AW),
    .C_M00_AXI_DATA_WIDTH(DW),
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_aresetn(s00_axi_aresetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_wstrb      (cmd_wstrb),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .rsp_timeout    (rsp_timeout),
    .err_count      (err_count),
    .busy           (busy),
    .m00_axi        (m00_axi)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  // ---------------- slave model knobs ----------------
  int            aw_delay = 0;
  int            w_delay  = 0;
  int            ar_delay = 0;
  logic          aw_never = 1'b0;
  logic          b_block  = 1'b0;
  logic [1:0]    bresp_val = 2'b00;
  logic [DW-1:0] rdata_val = '0;
  logic [1:0]    rresp_val = 2'b00;

  int   aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got;
  int   b_count;

  assign m00_axi.awready = m00_axi.awvalid && !aw_never && (aw_cnt >= aw_delay);
  assign m00_axi.wready  = m00_axi.wvalid && (w_cnt >= w_delay);
  assign m00_axi.arready = m00_axi.arvalid && (ar_cnt >= ar_delay);

  // Slave: wait-state counters, B after both AW and W, R after AR.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      m00_axi.bvalid <= 1'b0; m00_axi.bresp <= 2'b00;
      m00_axi.rvalid <= 1'b0; m00_axi.rdata <= '0; m00_axi.rresp <= 2'b00;
      b_count <= 0;
    end else begin
      aw_cnt <= (m00_axi.awvalid && !m00_axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m00_axi.wvalid && !m00_axi.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m00_axi.arvalid && !m00_axi.arready) ? ar_cnt + 1 : 0;
      if ((aw_got || (m00_axi.awvalid && m00_axi.awready)) &&
          (w_got || (m00_axi.wvalid && m00_axi.wready)) && !b_block) begin
        m00_axi.bvalid <= 1'b1;
        m00_axi.bresp  <= bresp_val;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got || (m00_axi.awvalid && m00_axi.awready);
        w_got  <= w_got || (m00_axi.wvalid && m00_axi.wready);
      end
      if (m00_axi.bvalid && m00_axi.bready) begin
        m00_axi.bvalid <= 1'b0;
        b_count <= b_count + 1;
      end
      if (m00_axi.arvalid && m00_axi.arready) begin
        m00_axi.rvalid <= 1'b1;
        m00_axi.rdata  <= rdata_val;
        m00_axi.rresp  <= rresp_val;
      end else if (m00_axi.rvalid && m00_axi.rready) begin
        m00_axi.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge s00_axi_aclk);
    #1;
  endtask

  // Present a command and return 1 unit after the accepting edge N.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s);
    int n = 0;
    @(negedge s00_axi_aclk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge s00_axi_aclk);
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge s00_axi_aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin
      step();
      n++;
    end
    chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic consume();
    $display("txn write=%0d rdata=%08h resp=%02b timeout=%0d err_count_before=%0d",
             rsp_write, rsp_rdata, rsp_resp, rsp_timeout, err_count);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Hold reset for the given cycles, check all outputs zero, then release.
  task automatic do_reset(input int cycles);
    @(negedge s00_axi_aclk);
    s00_axi_aresetn = 1'b0;
    repeat (cycles) @(posedge s00_axi_aclk);
    #1;
    chk("rst_ctrl", {51'd0, cmd_ready, busy, rsp_valid, rsp_write, rsp_timeout, rsp_resp,
                     m00_axi.awvalid, m00_axi.wvalid, m00_axi.bready,
                     m00_axi.arvalid, m00_axi.rready}, 64'd0);
    chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_err_count", {48'd0, err_count}, 64'd0);
    chk("rst_awaddr_wdata", {m00_axi.awaddr, m00_axi.wdata}, 64'd0);
    @(negedge s00_axi_aclk);
    s00_axi_aresetn = 1'b1;
    chk("cmd_ready_before_edge", {63'd0, cmd_ready}, 64'd0);
    step();
    chk("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hi;
    int b0;

    do_reset(3);

    // Zero-wait write: addr 0x4, data 0x55.
    send(1'b1, 32'h4, 32'h55, 4'hF);
    chk("zw_awvalid_n1", {63'd0, m00_axi.awvalid}, 64'd1);
    chk("zw_wvalid_n1", {63'd0, m00_axi.wvalid}, 64'd1);
    chk("zw_awaddr_n1", {32'd0, m00_axi.awaddr}, 64'h4);
    chk("zw_wdata_n1", {32'd0, m00_axi.wdata}, 64'h55);
    chk("zw_wstrb_n1", {60'd0, m00_axi.wstrb}, 64'hF);
    chk("zw_busy", {62'd0, busy, cmd_ready}, 64'b10);
    step();
    chk("zw_bready_n2", {62'd0, m00_axi.bready, rsp_valid}, 64'b10);
    step();
    chk("zw_rsp_valid_n3", {63'd0, rsp_valid}, 64'd1);
    chk("zw_rsp_fields", {rsp_rdata, 29'd0, rsp_write, rsp_resp}, 64'b100);
    consume();
    chk("zw_err_count", {48'd0, err_count}, 64'd0);
    chk("zw_back_to_idle", {62'd0, rsp_valid, cmd_ready}, 64'b01);

    // Skewed AW/W: AW at N+1, W at N+4.
    w_delay = 3;
    b0 = b_count;
    send(1'b1, 32'h0, 32'hABCD1234, 4'hF);
    chk("sk_valids_n1", {62'd0, m00_axi.awvalid, m00_axi.wvalid}, 64'b11);
    step();
    chk("sk_valids_n2", {62'd0, m00_axi.awvalid, m00_axi.wvalid}, 64'b01);
    step();
    chk("sk_valids_n3", {62'd0, m00_axi.awvalid, m00_axi.wvalid}, 64'b01);
    step();
    chk("sk_valids_n4", {61'd0, m00_axi.awvalid, m00_axi.wvalid, m00_axi.bready}, 64'b010);
    step();
    chk("sk_valids_n5", {61'd0, m00_axi.awvalid, m00_axi.wvalid, m00_axi.bready}, 64'b001);
    wait_rsp(10);
    chk("sk_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    consume();
    step();
    chk("sk_b_count", 64'(b_count - b0), 64'd1);
    w_delay = 0;

    // Read with arready after 2 wait cycles.
    ar_delay = 2;
    rdata_val = 32'hABCD1234;
    send(1'b0, 32'h0, 32'h0, 4'h0);
    chk("rd_arvalid_n1", {62'd0, m00_axi.arvalid, m00_axi.awvalid}, 64'b10);
    step();
    step();
    chk("rd_arvalid_n3", {62'd0, m00_axi.arvalid, m00_axi.rready}, 64'b10);
    step();
    chk("rd_rready_n4", {62'd0, m00_axi.arvalid, m00_axi.rready}, 64'b01);
    wait_rsp(10);
    chk("rd_rsp", {rsp_rdata, 29'd0, rsp_write, rsp_resp}, {32'hABCD1234, 32'd0});
    consume();
    ar_delay = 0;

    // Slave error with a stalled consumer.
    bresp_val = 2'b10;
    send(1'b1, 32'h8, 32'h1, 4'hF);
    wait_rsp(10);
    for (int i = 0; i < 5; i++) begin
      chk("err_hold", {61'd0, rsp_valid, rsp_resp}, 64'b110);
      step();
    end
    chk("err_count_before", {48'd0, err_count}, 64'd0);
    consume();
    chk("err_count_one", {48'd0, err_count}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 32'(i * 4), 32'(i), 4'hF);
      wait_rsp(10);
      consume();
    end
    chk("err_count_six", {48'd0, err_count}, 64'd6);
    bresp_val = 2'b00;

    // AW never ready: timeout (when built in) or indefinite wait.
    aw_never = 1'b1;
    send(1'b1, 32'hC, 32'h77, 4'hF);
    hi = 0;
    for (int i = 0; i < 120; i++) begin
      if (m00_axi.awvalid) hi++;
      step();
    end
`ifdef AXIL_TIMEOUT_EN
    chk("to_awvalid_cycles", 64'(hi), 64'(TO));
    chk("to_rsp", {60'd0, rsp_valid, rsp_timeout, rsp_resp}, 64'b1110);
    chk("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    consume();
    chk("to_err_count", {48'd0, err_count}, 64'd7);
`else
    chk("hang_awvalid_cycles", 64'(hi), 64'd120);
    chk("hang_no_rsp", {62'd0, rsp_valid, rsp_timeout}, 64'd0);
`endif
    aw_never = 1'b0;
    do_reset(2);

    // Reset asserted while waiting in WR_B.
    b_block = 1'b1;
    send(1'b1, 32'h10, 32'h99, 4'hF);
    step();
    chk("mid_in_wr_b", {63'd0, m00_axi.bready}, 64'd1);
    do_reset(1);
    b_block = 1'b0;

    // Fresh write after reset.
    send(1'b1, 32'h14, 32'h1234, 4'h3);
    wait_rsp(10);
    chk("post_rst_rsp", {61'd0, rsp_write, rsp_resp}, 64'b100);
    consume();
    chk("post_rst_err", {48'd0, err_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
